// File: rtl/sm_ddiff_pkg.sv
// sm_pkg: shared sign-magnitude types and arithmetic for the delayed differentiator.
package sm_pkg;
  localparam int SM_DEPTH_MAX = 64;
  localparam int SM_WMAX = 64;
  typedef struct packed {
    logic sign;
    logic [SM_WMAX-1:0] mag;
  } sm_t;
  typedef struct packed {
    logic sign;
    logic [SM_WMAX-1:0] mag;
    logic ovf;
  } sm_res_t;
  function automatic sm_t sm_norm(sm_t x);
    sm_t r;
    r = x;
    r.sign = x.sign & (x.mag != '0);
    return r;
  endfunction
  // a - b at magnitude width w; operands are zero-extended to SM_WMAX
  function automatic sm_res_t sm_sub(sm_t a, sm_t b, int unsigned w, logic sat);
    logic [SM_WMAX:0] s;
    logic [SM_WMAX-1:0] m;
    logic ge;
    sm_res_t r;
    m = (SM_WMAX'(1) << w) - 1'b1;
    s = {1'b0, a.mag} + {1'b0, b.mag};
    ge = a.mag >= b.mag;
    r.ovf = (a.sign != b.sign) && s[w[6:0]];
    r.mag = (a.sign == b.sign) ? (ge ? a.mag - b.mag : b.mag - a.mag) :
            (r.ovf && sat) ? m : s[SM_WMAX-1:0] & m;
    r.sign = (a.sign == b.sign) ? (ge ? a.sign : ~a.sign) : a.sign;
    r.sign = r.sign & (r.mag != '0);
    return r;
  endfunction
endpackage

// File: rtl/sm_ddiff_if.sv
// sm_ddiff_if: sample/result bus of the delayed differentiator.
interface sm_ddiff_if #(parameter int W = 16);
  logic clr;
  logic in_valid;
  logic [W-1:0] a_mag;
  logic a_sign;
  logic out_valid;
  logic [W-1:0] c_mag;
  logic c_sign;
  logic ovf;
  logic primed;
  modport master (output clr, in_valid, a_mag, a_sign, input out_valid, c_mag, c_sign, ovf, primed);
  modport slave (input clr, in_valid, a_mag, a_sign, output out_valid, c_mag, c_sign, ovf, primed);
endinterface

// File: rtl/sm_delay_line.sv
// sm_delay_line: circular history buffer; q is the oldest entry, i.e. the slot about to be overwritten.
module sm_delay_line #(
  parameter int WD = 17,
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic we,
  input  logic [WD-1:0] d,
  output logic [WD-1:0] q
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WD-1:0] mem [DEPTH];
  logic [PW-1:0] ptr, nxt;
  assign nxt = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  assign q = mem[ptr];
  // a sample accepted with clr lands in slot 0 of the freshly cleared buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      ptr <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= (i == 0 && we) ? d : '0;
      ptr <= we ? PW'(DEPTH > 1) : '0;
    end else if (we) begin
      mem[ptr] <= d;
      ptr <= nxt;
    end
  end
endmodule

// File: rtl/sm_ddiff.sv
// sm_ddiff: sign-magnitude delayed differentiator C = A(n) - A(n-DEPTH), 1-cycle latency.
// Define SM_DDIFF_SAT_EN to saturate c_mag on overflow instead of wrapping.
module sm_ddiff
  import sm_pkg::*;
#(
  parameter int W = 16,
  parameter int DEPTH = 1
) (
  input logic clk,
  input logic rst,
  sm_ddiff_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
`ifdef SM_DDIFF_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif
  if (DEPTH < 1 || DEPTH > SM_DEPTH_MAX) begin : g_bad_depth
    $error("sm_ddiff: DEPTH out of range 1..SM_DEPTH_MAX");
  end
  if (W < 1 || W >= SM_WMAX) begin : g_bad_w
    $error("sm_ddiff: W out of range");
  end
  logic [W:0] old;
  logic [CW-1:0] cnt;
  sm_t a, b;
  sm_res_t r;
  logic unused;
  assign a = sm_norm({bus.a_sign, SM_WMAX'(bus.a_mag)});
  // clr empties history this very cycle, so the old tap reads +0
  assign b = bus.clr ? '0 : {old[W], SM_WMAX'(old[W-1:0])};
  assign r = sm_sub(a, b, W, SAT);
  assign unused = ^{r.mag, a.mag};
  assign bus.primed = cnt == CW'(DEPTH);
  sm_delay_line #(.WD(W + 1), .DEPTH(DEPTH)) dl (
    .clk(clk),
    .rst(rst),
    .clr(bus.clr),
    .we(bus.in_valid),
    .d({a.sign, a.mag[W-1:0]}),
    .q(old)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.c_mag <= '0;
      bus.c_sign <= 1'b0;
      bus.ovf <= 1'b0;
      cnt <= '0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.c_mag <= r.mag[W-1:0];
        bus.c_sign <= r.sign;
        bus.ovf <= r.ovf;
      end
      cnt <= bus.clr ? CW'(bus.in_valid) : (bus.in_valid && !bus.primed) ? cnt + 1'b1 : cnt;
    end
  end
endmodule
